shreg_ctrl: RTL and testbench
=============================

Name: shreg_ctrl

Overview:
- Round-robin controller that shares one WIDTH-bit LED shift register between two byte requesters.
- Grants one requester at a time and captures its byte.
- Serialises the byte onto the register's serial input at a prescaled rate, qualified by a shift-enable strobe.
- Issues a one-cycle latch pulse when the full word is in place. Sits between pattern sources and the LED shift register.

Parameters:
- WIDTH, 8, bits per transfer; equals shift register length.
- DIV, 4, clock cycles per shifted bit; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  per-requester request; held with data until matching gnt bit seen.
- data0  input  WIDTH  requester 0 word.
- data1  input  WIDTH  requester 1 word.
- gnt  output  2  one-cycle registered grant pulse, one-hot.
- done  output  2  one-cycle completion pulse to the granted requester.
- sin  output  1  serial data to shift register.
- sh_en  output  1  shift-register clock enable, one cycle per bit.
- latch  output  1  one-cycle pulse after the last bit.
- busy  output  1  high from grant cycle through latch cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, shadow register 0, bit counter 0, prescaler 0, state IDLE, last-grant pointer = 1 (requester 0 wins first tie).
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - On a rising edge with any req bit set, pick the winner.
  - If only one req bit is set, that requester wins.
  - If both are set, the requester not indicated by the last-grant pointer wins.
  - On that edge: gnt[winner]=1, shadow <= data of winner, pointer <= winner, prescaler <= DIV-1, bit counter <= 0, state -> SHIFT.
  - busy rises in the same cycle as gnt.
- SHIFT, each cycle:
  - If prescaler != 0: decrement it.
  - If prescaler == 0: assert sh_en combinationally from state/counter for this cycle only, then at the edge shift shadow left by one inserting 0, increment bit counter, reload prescaler to DIV-1.
  - sin = shadow[WIDTH-1] combinationally, so sin is stable and valid whenever sh_en is high.
  - After the WIDTH-th sh_en -> LATCH.
  - First sh_en occurs DIV-1 cycles after the gnt cycle. DIV=1 gives back-to-back sh_en starting in the gnt cycle.
- LATCH:
  - latch=1 and done[pointer]=1 for exactly one cycle, busy=1, then -> IDLE.
  - busy=0 in IDLE.
- Timing:
  - Total busy cycles = WIDTH*DIV + 1.
  - Minimum req-to-gnt latency: 1 edge.
  - Next grant can be issued on the edge that leaves LATCH's following IDLE cycle; no back-to-back overlap.
- req asserted while busy is ignored (no queueing) and is evaluated once back in IDLE.
- A req that drops before being granted is lost without error.
- sin=0 in IDLE and LATCH, because shadow has shifted out to zeros.
- rst_n asserted mid-transfer aborts it immediately:
  - No latch or done is produced.
  - The shift register contents downstream are undefined to the consumer.
- gnt, done and latch are never asserted for more than one consecutive cycle. gnt and done are always one-hot or zero.

Optional Feature:
- Macro SHREG_CTRL_LSB_FIRST_EN.
- Defined: shadow shifts right inserting 0 and sin = shadow[0], so bits leave LSB first.
- Undefined (default): MSB first as described in Behaviour.
- Timing, handshake and arbitration are identical in both builds.

Test Plan:
- Reset, DIV=4, req=01, data0=8'hA5 -> gnt=01 one cycle; sh_en pulses at gnt+3, +7, ..., +31; sin at the 8 pulses = 1,0,1,0,0,1,0,1; latch and done=01 at gnt+32; busy high 33 cycles.
- DIV=1, req=10, data1=8'h81 -> sh_en high 8 consecutive cycles starting at the gnt cycle; sin=1,0,0,0,0,0,0,1; latch the next cycle.
- From reset, req=11 held continuously with data0=8'h0F, data1=8'hF0 -> grants alternate 01,10,01,10; each latch preceded by the correct 8-bit serial pattern.
- req0 pulsed during an active requester-1 transfer and held -> no gnt until after latch; gnt=01 on the first IDLE edge.
- rst_n low at the 4th sh_en of a transfer -> all outputs 0 asynchronously; no latch or done; after release, req=01 with 8'h3C completes normally with requester 0 priority.
- Build with SHREG_CTRL_LSB_FIRST_EN, data0=8'h01 -> sin=1 at the first sh_en, 0 at the remaining 7.

Source files
------------

// File: rtl/shreg_ctrl.sv
// shreg_ctrl: round-robin arbiter that shares one WIDTH-bit LED shift register
// between two byte requesters. The granted word is captured into a shadow
// register, shifted out on sin at one bit every DIV clocks (qualified by
// sh_en), and followed by a one-cycle latch pulse plus a done pulse back to
// the granted requester.
//
// Build option: define SHREG_CTRL_LSB_FIRST_EN to send bits LSB first.
// Without it (default) bits leave MSB first. Timing, handshake and
// arbitration are the same in both builds.
module shreg_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             sin,
    output logic             sh_en,
    output logic             latch,
    output logic             busy
);

    // Bit counter only needs to reach WIDTH-1; the transfer ends on that bit.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Prescaler is sized for the full DIV range of 1..65535.
    localparam int PRE_W = 16;
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              ptr_q, ptr_d;      // index of the last granted requester
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              latch_q, latch_d;
    logic              busy_q, busy_d;

    logic              shift_now;         // this cycle carries a bit to the register
    logic              winner;            // arbitration result in IDLE
    logic [WIDTH-1:0]  shadow_shifted;

    // Arbitration: a lone request wins; on a tie the requester that was not
    // granted last time wins, so two persistent requesters alternate.
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~ptr_q;
            default: winner = 1'b0;
        endcase
    end

    // Shift the shadow one place toward the serial output, filling with zero
    // so that sin naturally reads 0 once the word has gone out.
    always_comb begin
`ifdef SHREG_CTRL_LSB_FIRST_EN
        shadow_shifted = {1'b0, shadow_q[WIDTH-1:1]};
`else
        shadow_shifted = {shadow_q[WIDTH-2:0], 1'b0};
`endif
    end

    // Bit strobe is decoded straight from state and prescaler so it lines up
    // with the current head of the shadow register.
    always_comb begin
        shift_now = (state_q == ST_SHIFT) && (pre_q == '0);
    end

    // Next-state and registered-output logic for the IDLE/SHIFT/LATCH sequence.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        latch_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    gnt_d    = winner ? 2'b10 : 2'b01;
                    shadow_d = winner ? data1 : data0;
                    ptr_d    = winner;
                    pre_d    = PRE_RELOAD;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (!shift_now) begin
                    pre_d = pre_q - PRE_W'(1);
                end else begin
                    shadow_d = shadow_shifted;
                    pre_d    = PRE_RELOAD;
                    if (cnt_q == CNT_LAST) begin
                        // Last bit is leaving: present latch/done next cycle.
                        cnt_d   = '0;
                        latch_d = 1'b1;
                        done_d  = ptr_q ? 2'b10 : 2'b01;
                        state_d = ST_LATCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_LATCH: begin
                // Always spend one IDLE cycle before the next grant.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            pre_q    <= '0;
            ptr_q    <= 1'b1;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            latch_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
        end
    end

    // Serial head of the shadow register.
    always_comb begin
`ifdef SHREG_CTRL_LSB_FIRST_EN
        sin = shadow_q[0];
`else
        sin = shadow_q[WIDTH-1];
`endif
    end

    assign sh_en = shift_now;
    assign gnt   = gnt_q;
    assign done  = done_q;
    assign latch = latch_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_shreg_ctrl.sv
// Directed bench for shreg_ctrl: one DIV=4 instance and one DIV=1 instance.
// Build option SHREG_CTRL_LSB_FIRST_EN selects the expected bit order.
module tb_shreg_ctrl;

    logic       clk;
    logic       rst_n;

    logic [1:0] a_req, b_req;
    logic [7:0] a_data0, a_data1, b_data0, b_data1;
    logic [1:0] a_gnt, a_done, b_gnt, b_done;
    logic       a_sin, a_sh_en, a_latch, a_busy;
    logic       b_sin, b_sh_en, b_latch, b_busy;

    // Observation mux: sel=0 watches the DIV=4 instance, sel=1 the DIV=1 one.
    logic       sel;
    logic [1:0] o_gnt, o_done;
    logic       o_sin, o_sh_en, o_latch, o_busy;

    int n_cmp = 0;
    int n_err = 0;

    shreg_ctrl #(.WIDTH(8), .DIV(4)) u_div4 (
        .clk(clk), .rst_n(rst_n), .req(a_req), .data0(a_data0), .data1(a_data1),
        .gnt(a_gnt), .done(a_done), .sin(a_sin), .sh_en(a_sh_en),
        .latch(a_latch), .busy(a_busy)
    );

    shreg_ctrl #(.WIDTH(8), .DIV(1)) u_div1 (
        .clk(clk), .rst_n(rst_n), .req(b_req), .data0(b_data0), .data1(b_data1),
        .gnt(b_gnt), .done(b_done), .sin(b_sin), .sh_en(b_sh_en),
        .latch(b_latch), .busy(b_busy)
    );

    always_comb begin
        o_gnt   = sel ? b_gnt   : a_gnt;
        o_done  = sel ? b_done  : a_done;
        o_sin   = sel ? b_sin   : a_sin;
        o_sh_en = sel ? b_sh_en : a_sh_en;
        o_latch = sel ? b_latch : a_latch;
        o_busy  = sel ? b_busy  : a_busy;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected serial bit i (0 = first bit sent) of byte d.
    function automatic logic expbit(input logic [7:0] d, input int i);
`ifdef SHREG_CTRL_LSB_FIRST_EN
        return d[i];
`else
        return d[7-i];
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   32'(o_gnt),   32'h0);
        chk({tag, "_done"},  32'(o_done),  32'h0);
        chk({tag, "_sin"},   32'(o_sin),   32'h0);
        chk({tag, "_sh_en"}, 32'(o_sh_en), 32'h0);
        chk({tag, "_latch"}, 32'(o_latch), 32'h0);
        chk({tag, "_busy"},  32'(o_busy),  32'h0);
    endtask

    // Called at a negedge where req is already driven so the next posedge
    // grants. Walks gnt cycle (c=0) through the latch cycle (c=8*div), then
    // checks the following IDLE cycle and returns at that negedge.
    task automatic xfer(input bit s, input int div, input logic [1:0] exp_gnt,
                        input logic [7:0] data, input logic [1:0] drop,
                        input logic [1:0] mid_set, input string tag);
        int  last;
        bit  exp_sh;
        last = 8 * div;
        sel  = s;
        @(negedge clk);
        for (int c = 0; c <= last; c++) begin
            if (c == 0) begin
                chk({tag, "_gnt"}, 32'(o_gnt), 32'(exp_gnt));
                if (s) b_req = b_req & ~drop;
                else   a_req = a_req & ~drop;
            end else begin
                chk({tag, "_gnt_idle"}, 32'(o_gnt), 32'h0);
            end
            chk({tag, "_busy"}, 32'(o_busy), 32'h1);
            exp_sh = (c < last) && ((c % div) == (div - 1));
            chk({tag, "_sh_en"}, 32'(o_sh_en), 32'(exp_sh));
            if (exp_sh)
                chk({tag, "_sin"}, 32'(o_sin), 32'(expbit(data, c / div)));
            chk({tag, "_latch"}, 32'(o_latch), (c == last) ? 32'h1 : 32'h0);
            chk({tag, "_done"}, 32'(o_done), (c == last) ? 32'(exp_gnt) : 32'h0);
            if (c == 5) begin
                if (s) b_req = b_req | mid_set;
                else   a_req = a_req | mid_set;
            end
            @(negedge clk);
        end
        chk_all_zero({tag, "_idle"});
    endtask

    initial begin
        sel = 1'b0;
        rst_n = 1'b1;
        a_req = 2'b00; b_req = 2'b00;
        a_data0 = 8'h00; a_data1 = 8'h00; b_data0 = 8'h00; b_data1 = 8'h00;

        // Reset state of both instances.
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        sel = 1'b0; chk_all_zero("rst_a");
        sel = 1'b1; chk_all_zero("rst_b");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // DIV=4, requester 0 alone with A5.
        a_req = 2'b01; a_data0 = 8'hA5;
        xfer(1'b0, 4, 2'b01, 8'hA5, 2'b01, 2'b00, "t1");

        // DIV=1, requester 1 alone with 81: back-to-back strobes from gnt cycle.
        b_req = 2'b10; b_data1 = 8'h81;
        xfer(1'b1, 1, 2'b10, 8'h81, 2'b10, 2'b00, "t2");

        // Both requesting continuously from reset: grants alternate.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a_req = 2'b11; a_data0 = 8'h0F; a_data1 = 8'hF0;
        xfer(1'b0, 4, 2'b01, 8'h0F, 2'b00, 2'b00, "t3a");
        xfer(1'b0, 4, 2'b10, 8'hF0, 2'b00, 2'b00, "t3b");
        xfer(1'b0, 4, 2'b01, 8'h0F, 2'b00, 2'b00, "t3c");
        xfer(1'b0, 4, 2'b10, 8'hF0, 2'b00, 2'b00, "t3d");
        a_req = 2'b00;

        // Requester 0 raised mid-transfer of requester 1: waits for IDLE.
        a_req = 2'b10; a_data1 = 8'h96; a_data0 = 8'h5A;
        xfer(1'b0, 4, 2'b10, 8'h96, 2'b10, 2'b01, "t4a");
        xfer(1'b0, 4, 2'b01, 8'h5A, 2'b01, 2'b00, "t4b");

        // Reset on the 4th strobe aborts the transfer.
        sel = 1'b0;
        a_req = 2'b01; a_data0 = 8'hE7;
        @(negedge clk);
        chk("t5_gnt", 32'(a_gnt), 32'h1);
        a_req = 2'b00;
        repeat (15) @(negedge clk);
        chk("t5_4th_sh_en", 32'(a_sh_en), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("t5_no_latch", 32'(a_latch), 32'h0);
            chk("t5_no_done", 32'(a_done), 32'h0);
        end
        // Tie after reset goes to requester 0 again.
        a_req = 2'b11; a_data0 = 8'h3C; a_data1 = 8'hC3;
        xfer(1'b0, 4, 2'b01, 8'h3C, 2'b11, 2'b00, "t5_post");

        // Single set bit in bit 0: position of the 1 depends on bit order.
        a_req = 2'b01; a_data0 = 8'h01;
        xfer(1'b0, 4, 2'b01, 8'h01, 2'b01, 2'b00, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
